// File: rtl/sync_serial_sub8_pkg.sv
// Shared definitions for the bit-serial subtractor: default width and FSM states.
package sync_serial_sub8_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/sync_serial_sub8_full_sub1.sv
// Combinational 1-bit full subtractor: d = a - b - bin, with borrow-out.
module full_sub1 (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/sync_serial_sub8.sv
// Bit-serial subtractor D = A - B - Bin, one bit per clock, LSB first.
// A start/done handshake brackets each operation; results hold until the next done.
import sync_serial_sub8_pkg::*;

module sync_serial_sub8 #(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   aSh_q, aSh_d;
    logic [WIDTH-1:0]   bSh_q, bSh_d;
    logic [WIDTH-2:0]   res_q, res_d;
    logic               br_q, br_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic               bitD;
    logic               bitBout;
    logic [WIDTH-1:0]   shifted;

    full_sub1 u_bit (
        .a_i    (aSh_q[0]),
        .b_i    (bSh_q[0]),
        .bin_i  (br_q),
        .d_o    (bitD),
        .bout_o (bitBout)
    );

    // The result register is one bit short: the final bit goes straight into D.
    assign shifted = {bitD, res_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        aSh_d   = aSh_q;
        bSh_d   = bSh_q;
        res_d   = res_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    aSh_d   = A;
                    bSh_d   = B;
                    br_d    = Bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                aSh_d = aSh_q >> 1;
                bSh_d = bSh_q >> 1;
                br_d  = bitBout;
                res_d = shifted[WIDTH-1:1];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // At the last bit the operand LSBs are the original sign bits.
                    diff_d  = shifted;
                    bout_d  = bitBout;
                    ovf_d   = (aSh_q[0] != bSh_q[0]) && (bitD != aSh_q[0]);
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            aSh_q   <= '0;
            bSh_q   <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            aSh_q   <= aSh_d;
            bSh_q   <= bSh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == S_SHIFT);
    assign done = done_q;
    assign D    = diff_q;
    assign Bout = bout_q;
    assign V    = ovf_q;

endmodule

// File: tb/tb_sync_serial_sub8.sv
// Self-checking bench for sync_serial_sub8: arithmetic reference model plus directed vectors.
module tb_sync_serial_sub8;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         Bin   = 1'b0;
    logic [W-1:0] A     = '0;
    logic [W-1:0] B     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] D;
    logic         Bout;
    logic         V;

    int checks = 0;
    int passes = 0;

    sync_serial_sub8 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .Bout  (Bout),
        .V     (V)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: an accepted request completes WIDTH edges later with plain integer arithmetic.
    int           mRemain = 0;
    logic [W-1:0] mA = '0, mB = '0, mD = '0;
    logic         mBin = 1'b0, mDone = 1'b0, mBout = 1'b0, mV = 1'b0;
    int           uDiff, sDiff;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mRemain = 0;
            mDone   = 1'b0;
            mD      = '0;
            mBout   = 1'b0;
            mV      = 1'b0;
        end else begin
            mDone = 1'b0;
            if (mRemain > 0) begin
                mRemain--;
                if (mRemain == 0) begin
                    uDiff = int'(mA) - int'(mB) - int'(mBin);
                    sDiff = int'($signed(mA)) - int'($signed(mB)) - int'(mBin);
                    mD    = W'(uDiff);
                    mBout = (uDiff < 0);
                    mV    = (sDiff < -(1 << (W - 1))) || (sDiff > (1 << (W - 1)) - 1);
                    mDone = 1'b1;
                end
            end else if (start) begin
                mA      = A;
                mB      = B;
                mBin    = Bin;
                mRemain = W;
            end
        end
    end

    logic prevDone = 1'b0;

    always @(negedge clk) begin
        check("model.done", done, mDone);
        check("model.busy", busy, mRemain > 0);
        check("model.D", D, mD);
        check("model.Bout", Bout, mBout);
        check("model.V", V, mV);
        if (done) check("donePulseWidth", prevDone, 1'b0);
        prevDone = done;
    end

    task automatic checkOutput(input string name, input logic [W-1:0] expD,
                               input logic expBout, input logic expV);
        check({name, ".D"}, D, expD);
        check({name, ".Bout"}, Bout, expBout);
        check({name, ".V"}, V, expV);
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic bin, output int cyc);
        @(negedge clk);
        A     = a;
        B     = b;
        Bin   = bin;
        start = 1'b1;
        cyc   = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (done) begin
                cyc = n;
                break;
            end
        end
        if (cyc == 0) check("doneTimeout", done, 1'b1);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo;
        logic         v;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int cyc;
        int doneCount;
        int lastAt;

        vecs[0] = '{8'd15,  8'd15,  1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{8'd85,  8'd170, 1'b1, 8'hAA, 1'b1, 1'b1};
        vecs[2] = '{8'd0,   8'd255, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'd0,   8'd0,   1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[4] = '{8'd128, 8'd1,   1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[5] = '{8'd127, 8'd255, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[6] = '{8'd100, 8'd50,  1'b1, 8'h31, 1'b0, 1'b0};

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.busy", busy, 1'b0);
        check("reset.done", done, 1'b0);
        checkOutput("reset", 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic directed vectors, including the latency of the first one.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin, cyc);
            if (i == 0) check("T1.latency", cyc, 9);
            checkOutput($sformatf("vec%0d", i), vecs[i].d, vecs[i].bo, vecs[i].v);
        end

        // A start pulse during SHIFT must not disturb the in-flight operation.
        @(negedge clk);
        A = 8'd200; B = 8'd1; Bin = 1'b0; start = 1'b1;
        cyc = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n == 2) begin A = 8'd0; B = 8'd1; start = 1'b1; end
            if (n == 3) start = 1'b0;
            if (done) begin
                cyc = n;
                break;
            end
        end
        if (cyc == 0) check("T4.doneTimeout", done, 1'b1);
        check("T4.latency", cyc, 9);
        checkOutput("T4", 8'hC7, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("T4.idle", busy, 1'b0);

        // Reset mid-operation: outputs clear immediately, no done follows.
        @(negedge clk);
        A = 8'd15; B = 8'd3; Bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("T5.busyBefore", busy, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("T5.busy", busy, 1'b0);
        check("T5.done", done, 1'b0);
        checkOutput("T5", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            check("T5.noDone", done, 1'b0);
        end

        // Holding start gives back-to-back operations every WIDTH+1 cycles.
        @(negedge clk);
        A = 8'd1; B = 8'd1; Bin = 1'b1; start = 1'b1;
        doneCount = 0;
        lastAt    = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (done) begin
                doneCount++;
                check("T6.period", n - lastAt, 9);
                lastAt = n;
                checkOutput("T6", 8'hFF, 1'b1, 1'b0);
            end
        end
        start = 1'b0;
        check("T6.doneCount", doneCount, 3);
        repeat (12) @(negedge clk);
        check("T6.drained", busy, 1'b0);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
